// File: rtl/pipe_align_delay.sv
// Sideband delay line that keeps per-operand side fields aligned with a
// DEPTH-stage arithmetic pipeline. It supports stall, flush and occupancy tracking.
module pipe_align_delay #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 7,
    localparam int unsigned DW      = CHANNELS * WIDTH,
    localparam int unsigned OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic [OCC_W-1:0] occupancy
);

    // Index 0 holds stage 1 and index DEPTH-1 holds stage DEPTH.
    logic [DEPTH-1:0] v_q;
    logic [DW-1:0]    d_q [DEPTH];
    logic [OCC_W-1:0] occ_d;

    // Stage valid bits: flush beats stall, and stall freezes everything.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            v_q <= '0;
        end else if (flush) begin
            v_q <= '0;
        end else if (!stall) begin
            v_q[0] <= in_valid;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                v_q[k] <= v_q[k-1];
            end
        end
    end

    // Data stages load on every advance; validity is carried only by v_q.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                d_q[k] <= '0;
            end
        end else if (!stall && !flush) begin
            d_q[0] <= in_data;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                d_q[k] <= d_q[k-1];
            end
        end
    end

    // Occupancy next-state: an entry enters at stage 1 and leaves from stage DEPTH.
    always_comb begin
        occ_d = occupancy;
        if (flush) begin
            occ_d = '0;
        end else if (!stall) begin
            occ_d = occupancy + OCC_W'(in_valid) - OCC_W'(v_q[DEPTH-1]);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_d;
        end
    end

    // Output mask taken straight from stage DEPTH; it has no path from the inputs.
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = v_q[DEPTH-1] ? d_q[DEPTH-1] : '0;

    // The counter must always match the number of live stages.
    a_occ_popcount: assert property (@(posedge clk) disable iff (!clear_n)
        occupancy == OCC_W'($countones(v_q)));

    a_occ_bound: assert property (@(posedge clk) disable iff (!clear_n)
        occupancy <= OCC_W'(DEPTH));

endmodule
